// File: rtl/fpnew_pkg.sv
// Shared FPU types used across the fpnew blocks.
// Only the IEEE exception-flag bundle is needed by the writeback buffer.
`timescale 1ns/1ps
package fpnew_pkg;

    // Exception flags: invalid, divide-by-zero, overflow, underflow, inexact.
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_wb_buffer.sv
// Writeback FIFO for FP results with status/tag, plus sticky accrued flags.
// Outputs come straight from registered storage; no fall-through path.
`timescale 1ns/1ps
module fpnew_wb_buffer import fpnew_pkg::*; #(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [Width-1:0]           result_i,
    input  status_t                    status_i,
    input  TagType                     tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Width-1:0]           result_o,
    output status_t                    status_o,
    output TagType                     tag_o,
    input  logic                       fflags_clear_i,
    output status_t                    fflags_o,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth+1);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        TagType           tag;
    } entry_t;

    entry_t          mem [Depth];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   usage;
    logic            push, pop;

    // Ready depends only on the registered count, so out_ready_i never reaches it.
    assign in_ready_o  = (usage != CW'(Depth));
    assign out_valid_o = (usage != '0);
    assign busy_o      = out_valid_o;
    assign usage_o     = usage;

    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    // Entry storage is intentionally left out of reset.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= '{result: result_i, status: status_i, tag: tag_i};
    end

    assign result_o = mem[rd_ptr].result;
    assign status_o = mem[rd_ptr].status;
    assign tag_o    = mem[rd_ptr].tag;

    // Pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   usage <= usage + CW'(1);
                2'b01:   usage <= usage - CW'(1);
                default: usage <= usage;
            endcase
        end
    end

    // Clear with a same-cycle pop restarts accumulation from the popped flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fflags_o <= '0;
        end else if (pop) begin
            fflags_o <= fflags_clear_i ? status_o : (fflags_o | status_o);
        end else if (fflags_clear_i) begin
            fflags_o <= '0;
        end
    end

endmodule
